// File: rtl/reqgnt_responder.sv
// Grant side of req/gnt: each req gets one gnt pulse MIN_LAT..MAX_LAT cycles later, in order.
// Latency is the per-request clamped lat_cfg. stall defers a due grant until it reaches MAX_LAT.
module reqgnt_responder #(
  parameter int MIN_LAT = 2,
  parameter int MAX_LAT = 8,
  parameter int DEPTH   = MAX_LAT,
  parameter int LAT_W   = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req,
  input  logic [LAT_W-1:0]           lat_cfg,
  input  logic                       stall,
  output logic                       gnt,
  output logic [$clog2(DEPTH+1)-1:0] outstanding,
  output logic                       overflow_err
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [LAT_W-1:0] MIN_L    = LAT_W'(MIN_LAT);
  localparam logic [LAT_W-1:0] MAX_L    = LAT_W'(MAX_LAT);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DEPTH-1:0] ent_vld;
  logic [LAT_W-1:0] ent_age [DEPTH];
  logic [LAT_W-1:0] ent_tgt [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  logic             head_vld;
  logic [LAT_W-1:0] head_age;
  logic [LAT_W-1:0] head_tgt;
  logic [LAT_W-1:0] tgt_clamped;
  logic             full;
  logic             push;
  logic             pop;

  always_comb begin
    head_vld = ent_vld[rd_ptr];
    head_age = ent_age[rd_ptr];
    head_tgt = ent_tgt[rd_ptr];

    if (lat_cfg < MIN_L)      tgt_clamped = MIN_L;
    else if (lat_cfg > MAX_L) tgt_clamped = MAX_L;
    else                      tgt_clamped = lat_cfg;

    // Grant depends only on registered head state and stall, never on req.
    gnt  = head_vld && (head_age >= head_tgt) && (!stall || (head_age == MAX_L));
    pop  = gnt;
    full = (outstanding == FULL_CNT);
    push = req && (!full || pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_vld <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_age[i] <= '0;
        ent_tgt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ent_vld[i] && !(pop && (rd_ptr == PTR_W'(i))) && (ent_age[i] != MAX_L))
          ent_age[i] <= ent_age[i] + 1'b1;
      end
      if (pop)
        ent_vld[rd_ptr] <= 1'b0;
      // When full, wr_ptr == rd_ptr; the push below deliberately overrides the pop.
      if (push) begin
        ent_vld[wr_ptr] <= 1'b1;
        ent_age[wr_ptr] <= LAT_W'(1);
        ent_tgt[wr_ptr] <= tgt_clamped;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      outstanding  <= '0;
      overflow_err <= 1'b0;
    end else begin
      if (pop)
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      if (push)
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      outstanding <= outstanding + CNT_W'(push) - CNT_W'(pop);
      if (req && full && !pop)
        overflow_err <= 1'b1;
    end
  end

  a_gnt_needs_head: assert property (@(posedge clk) disable iff (!rst_n) gnt |-> head_vld);
  a_cnt_bound:      assert property (@(posedge clk) disable iff (!rst_n) outstanding <= FULL_CNT);
  a_cnt_matches:    assert property (@(posedge clk) disable iff (!rst_n)
                                     CNT_W'($countones(ent_vld)) == outstanding);
  a_age_bound:      assert property (@(posedge clk) disable iff (!rst_n)
                                     head_vld |-> head_age <= MAX_L);

endmodule

// File: tb/tb_reqgnt_responder.sv
// Bench for reqgnt_responder: directed cycle tables, a mid-cycle reset sequence,
// and randomized traffic against an arrival-time queue model.
module tb_reqgnt_responder;

  localparam int MIN_LAT = 2;
  localparam int MAX_LAT = 8;
  localparam int DEPTH   = 8;
  localparam int LAT_W   = 4;
  localparam int CNT_W   = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req = 1'b0;
  logic [LAT_W-1:0] lat_cfg = '0;
  logic             stall = 1'b0;
  logic             gnt;
  logic [CNT_W-1:0] outstanding;
  logic             overflow_err;

  always #5 clk = ~clk;

  reqgnt_responder #(
    .MIN_LAT(MIN_LAT), .MAX_LAT(MAX_LAT), .DEPTH(DEPTH), .LAT_W(LAT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .lat_cfg(lat_cfg), .stall(stall),
    .gnt(gnt), .outstanding(outstanding), .overflow_err(overflow_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: each pending request remembers its arrival cycle and clamped target.
  typedef struct { int arr; int tgt; } ent_t;
  ent_t mq[$];
  int   cyc = 0;
  logic m_gnt;
  int   m_out;

  function automatic int clamp(input int v);
    if (v < MIN_LAT) return MIN_LAT;
    if (v > MAX_LAT) return MAX_LAT;
    return v;
  endfunction

  task automatic step(input logic rn, input logic r, input logic [LAT_W-1:0] l, input logic s);
    int age;
    @(negedge clk);
    rst_n = rn; req = r; lat_cfg = l; stall = s;
    #1;
    m_gnt = 1'b0;
    m_out = 0;
    if (!rn) begin
      mq.delete();
    end else begin
      m_out = mq.size();
      if (mq.size() > 0) begin
        age   = cyc - mq[0].arr;
        m_gnt = (age >= mq[0].tgt) && (!s || age >= MAX_LAT);
      end
      if (m_gnt) void'(mq.pop_front());
      if (r) mq.push_back('{cyc, clamp(int'(l))});
    end
    cyc++;
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b1, 4'd3, 1'b0);
    check("reset gnt", 32'(gnt), 0);
    check("reset outstanding", 32'(outstanding), 0);
    check("reset overflow_err", 32'(overflow_err), 0);
  endtask

  typedef struct { logic r; logic [LAT_W-1:0] lat; logic s; logic g; int o; } vec_t;
  vec_t tbl[$];

  task automatic add(input logic r, input int lat, input logic s, input logic g, input int o);
    tbl.push_back('{r, LAT_W'(lat), s, g, o});
  endtask

  task automatic run_table(input string name);
    do_reset();
    foreach (tbl[i]) begin
      step(1'b1, tbl[i].r, tbl[i].lat, tbl[i].s);
      check($sformatf("%s c%0d gnt", name, i), 32'(gnt), 32'(tbl[i].g));
      check($sformatf("%s c%0d outstanding", name, i), 32'(outstanding), 32'(tbl[i].o));
      check($sformatf("%s c%0d overflow_err", name, i), 32'(overflow_err), 0);
    end
    tbl.delete();
  endtask

  initial begin
    // Single request, latency 3.
    add(1, 3, 0, 0, 0); add(0, 0, 0, 0, 1); add(0, 0, 0, 0, 1);
    add(0, 0, 0, 1, 1); add(0, 0, 0, 0, 0); add(0, 0, 0, 0, 0);
    run_table("single_lat3");

    // Eight back-to-back requests at latency 2.
    for (int c = 0; c <= 10; c++)
      add(c <= 7, 2, 0, (c >= 2 && c <= 9),
          (c == 0) ? 0 : (c == 1) ? 1 : (c <= 8) ? 2 : (c == 9) ? 1 : 0);
    run_table("burst_lat2");

    // Clamping: lat_cfg 0 -> 2, lat_cfg 15 -> 8.
    for (int c = 0; c <= 10; c++)
      add(c <= 1, (c == 0) ? 0 : 15, 0, (c == 2 || c == 9),
          (c == 0) ? 0 : (c == 1) ? 1 : (c == 2) ? 2 : (c <= 9) ? 1 : 0);
    run_table("clamp");

    // Stall held: every grant forced at MAX_LAT, queue fills completely.
    for (int c = 0; c <= 16; c++)
      add(c <= 7, 2, 1, (c >= 8 && c <= 15), (c <= 8) ? c : 16 - c);
    run_table("stall_full");

    // Short stall window delays two lat-5 requests to latency 7.
    for (int c = 0; c <= 9; c++)
      add(c <= 1, 5, (c == 5 || c == 6), (c == 7 || c == 8),
          (c == 0) ? 0 : (c == 1) ? 1 : (c <= 7) ? 2 : (c == 8) ? 1 : 0);
    run_table("stall_window");

    // Mid-cycle asynchronous reset with three requests pending.
    do_reset();
    for (int c = 0; c < 3; c++) step(1'b1, 1'b1, 4'd4, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0);
    check("midrst c3 outstanding", 32'(outstanding), 3);
    step(1'b1, 1'b0, '0, 1'b0);
    check("midrst c4 gnt before reset", 32'(gnt), 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst gnt in reset", 32'(gnt), 0);
    check("midrst outstanding in reset", 32'(outstanding), 0);
    mq.delete();
    step(1'b0, 1'b0, '0, 1'b0);
    for (int c = 0; c < 10; c++) begin
      step(1'b1, 1'b0, '0, 1'b0);
      check($sformatf("midrst post c%0d gnt", c), 32'(gnt), 0);
      check($sformatf("midrst post c%0d outstanding", c), 32'(outstanding), 0);
    end
    step(1'b1, 1'b1, 4'd2, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0);
    check("midrst new c1 gnt", 32'(gnt), 0);
    step(1'b1, 1'b0, '0, 1'b0);
    check("midrst new c2 gnt", 32'(gnt), 1);

    // Randomized traffic with occasional resets, checked against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      logic rn, r, s;
      rn = ($urandom_range(0, 699) != 0);
      r  = ($urandom_range(0, 99) < 60);
      s  = ($urandom_range(0, 99) < ((c / 500) % 2 == 0 ? 30 : 80));
      step(rn, r, LAT_W'($urandom_range(0, 15)), s);
      check($sformatf("rand c%0d gnt", c), 32'(gnt), 32'(m_gnt));
      check($sformatf("rand c%0d outstanding", c), 32'(outstanding), 32'(m_out));
      check($sformatf("rand c%0d overflow_err", c), 32'(overflow_err), 0);
    end
    for (int c = 0; c < MAX_LAT + 2; c++) begin
      step(1'b1, 1'b0, '0, 1'b0);
      check($sformatf("drain c%0d gnt", c), 32'(gnt), 32'(m_gnt));
    end
    check("drain outstanding", 32'(outstanding), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
